display_scan_driver: RTL and testbench

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

---
 rtl/display_scan_driver.sv | 127 ++++++++++++
 tb/tb_display_scan_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with frame snapshot, ghost blanking and colon blink.
// Optional ALARM_FLASH_EN: alarm blanks the whole display in step with the colon.
module display_scan_driver #(
    parameter int unsigned SCAN_DIV     = 1024,
    parameter int unsigned DEAD_CYC     = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [13:0] hours_disp,
    input  logic [13:0] mins_disp,
    input  logic        AM_PM_disp,
    input  logic        SPEAKER_OUT,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  digit_en,
    output logic        colon_out
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_LIM  = PW'(DEAD_CYC);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    ZERO_PAT  = 7'b0111111;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [13:0]   hours_snap_q, hours_snap_d;
    logic [13:0]   mins_snap_q, mins_snap_d;
    logic          pm_snap_q, pm_snap_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    digit_q, digit_d;
    logic          colon_q, colon_d;

    logic          pcnt_wrap;
    logic          frame_start;
    logic          lead_zero;
    logic [6:0]    pattern;

`ifndef ALARM_FLASH_EN
    logic unused_speaker;
    assign unused_speaker = SPEAKER_OUT;
`endif

    // Scan counters, frame snapshot, blink divider and next output values
    always_comb begin
        pcnt_wrap   = (pcnt_q == PCNT_LAST);
        frame_start = (pcnt_q == '0) && (idx_q == 2'd0);
        pcnt_d      = pcnt_wrap ? '0 : pcnt_q + PW'(1);
        idx_d       = idx_q + 2'(pcnt_wrap);

        hours_snap_d = frame_start ? hours_disp : hours_snap_q;
        mins_snap_d  = frame_start ? mins_disp  : mins_snap_q;
        pm_snap_d    = frame_start ? AM_PM_disp : pm_snap_q;

        fcnt_d  = fcnt_q;
        colon_d = colon_q;
        if (pcnt_wrap && (idx_q == 2'd3)) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                colon_d = ~colon_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // Outputs use the snapshot valid for this cycle's frame, including the capture cycle
        case (idx_q)
            2'd0:    pattern = mins_snap_d[6:0];
            2'd1:    pattern = mins_snap_d[13:7];
            2'd2:    pattern = hours_snap_d[6:0];
            default: pattern = hours_snap_d[13:7];
        endcase
        lead_zero = (idx_q == 2'd3) && (hours_snap_d[13:7] == ZERO_PAT);

        seg_d   = '0;
        dp_d    = 1'b0;
        digit_d = '0;
        if ((pcnt_q >= DEAD_LIM) && !lead_zero) begin
            seg_d   = pattern;
            digit_d = 4'b0001 << idx_q;
            dp_d    = (idx_q == 2'd0) && pm_snap_d;
        end

`ifdef ALARM_FLASH_EN
        if (SPEAKER_OUT && !colon_d) begin
            digit_d = '0;
            dp_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            fcnt_q       <= '0;
            hours_snap_q <= '0;
            mins_snap_q  <= '0;
            pm_snap_q    <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            digit_q      <= '0;
            colon_q      <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            hours_snap_q <= hours_snap_d;
            mins_snap_q  <= mins_snap_d;
            pm_snap_q    <= pm_snap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_q      <= digit_d;
            colon_q      <= colon_d;
        end
    end

    assign seg_out   = seg_q;
    assign dp_out    = dp_q;
    assign digit_en  = digit_q;
    assign colon_out = colon_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Randomized bench for display_scan_driver (SCAN_DIV=8, DEAD_CYC=1, BLINK_FRAMES=2) with a slot/frame model.
module tb_display_scan_driver;

    localparam int SD = 8;
    localparam int DC = 1;
    localparam int BF = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] hours_disp = '0;
    logic [13:0] mins_disp = '0;
    logic        AM_PM_disp = 1'b0;
    logic        SPEAKER_OUT = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        colon_out;

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;
    bit started = 0;

    logic [13:0] snap_h = '0;
    logic [13:0] snap_m = '0;
    logic        snap_pm = 1'b0;
    logic        spk_prev = 1'b0;

    display_scan_driver #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset_n(reset_n), .hours_disp(hours_disp), .mins_disp(mins_disp),
        .AM_PM_disp(AM_PM_disp), .SPEAKER_OUT(SPEAKER_OUT), .seg_out(seg_out),
        .dp_out(dp_out), .digit_en(digit_en), .colon_out(colon_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // k = clock edges since the last reset edge; interval k shows outputs for scan position k-1
    always @(posedge clk) begin
        if (!reset_n) begin
            k = 0;
            started = 1;
        end else if (started) begin
            k = k + 1;
        end
    end

    // Reference model compare, every cycle after the first reset edge
    always @(negedge clk) begin
        if (started) begin
            int p, pc, ix;
            logic [6:0] pat;
            logic [3:0] e_dig;
            logic [6:0] e_seg;
            logic       e_dp;
            logic       e_col;
            e_dig = '0; e_seg = '0; e_dp = 1'b0;
            e_col = 1'((k / (FRAME * BF)) % 2);
            if (k > 0) begin
                p  = k - 1;
                pc = p % SD;
                ix = (p / SD) % 4;
                case (ix)
                    0: pat = snap_m[6:0];
                    1: pat = snap_m[13:7];
                    2: pat = snap_h[6:0];
                    default: pat = snap_h[13:7];
                endcase
                if (pc >= DC && !(ix == 3 && pat == 7'h3F)) begin
                    e_dig = 4'(1 << ix);
                    e_seg = pat;
                    e_dp  = (ix == 0) && snap_pm;
                end
`ifdef ALARM_FLASH_EN
                if (spk_prev && !e_col) begin
                    e_dig = '0;
                    e_dp  = 1'b0;
                end
`endif
            end
            chk("model_digit_en", int'(digit_en), int'(e_dig));
            chk("model_seg_out", int'(seg_out), int'(e_seg));
            chk("model_dp_out", int'(dp_out), int'(e_dp));
            chk("model_colon_out", int'(colon_out), int'(e_col));
            if (k % FRAME == 0) begin
                snap_h  = hours_disp;
                snap_m  = mins_disp;
                snap_pm = AM_PM_disp;
            end
            spk_prev = SPEAKER_OUT;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step(input bit lz_bias);
        if ($urandom_range(0, 11) == 0) mins_disp = 14'($urandom_range(0, 16383));
        if ($urandom_range(0, 11) == 0) begin
            hours_disp = 14'($urandom_range(0, 16383));
            if (lz_bias || $urandom_range(0, 3) == 0) hours_disp[13:7] = 7'h3F;
        end
        if ($urandom_range(0, 15) == 0) AM_PM_disp = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 40) == 0) SPEAKER_OUT = ~SPEAKER_OUT;
    endtask

    initial begin
        // Reset, then the reference pattern with hand-computed expectations
        repeat (3) tick();
        hours_disp = {7'h06, 7'h5B};
        mins_disp  = {7'h4F, 7'h66};
        AM_PM_disp = 1'b1;
        SPEAKER_OUT = 1'b0;
        chk("reset_digit_en", int'(digit_en), 0);
        chk("reset_seg_out", int'(seg_out), 0);
        chk("reset_colon", int'(colon_out), 0);
        reset_n = 1'b1;
        tick();                                   // k=1: slot 0 dead cycle
        chk("slot0_dead_digit", int'(digit_en), 0);
        chk("slot0_dead_dp", int'(dp_out), 0);
        tick();                                   // k=2
        chk("slot0_digit", int'(digit_en), 4'b0001);
        chk("slot0_seg", int'(seg_out), 7'h66);
        chk("slot0_dp_pm", int'(dp_out), 1);
        repeat (8) tick();                        // k=10
        chk("slot1_digit", int'(digit_en), 4'b0010);
        chk("slot1_seg", int'(seg_out), 7'h4F);
        chk("slot1_dp", int'(dp_out), 0);
        repeat (8) tick();                        // k=18
        chk("slot2_seg", int'(seg_out), 7'h5B);
        repeat (8) tick();                        // k=26
        chk("slot3_digit", int'(digit_en), 4'b1000);
        chk("slot3_seg", int'(seg_out), 7'h06);
        repeat (7) tick();                        // k=33: next frame dead cycle
        chk("frame2_dead", int'(digit_en), 0);
        repeat (30) tick();                       // k=63
        chk("colon_before_64", int'(colon_out), 0);
        tick();                                   // k=64
        chk("colon_at_64", int'(colon_out), 1);
        repeat (63) tick();                       // k=127
        chk("colon_before_128", int'(colon_out), 1);
        tick();                                   // k=128
        chk("colon_at_128", int'(colon_out), 0);

        // Leading-zero hours tens blanks slot 3 from the next frame
        hours_disp = {7'h3F, 7'h5B};
        repeat (32 + 26 - 128 % 32) tick();       // k=186: slot 3, pcnt 1 of frame 5
        chk("lz_slot3_blank", int'(digit_en), 0);

        // Randomized run
        for (int i = 0; i < 800; i++) begin
            tick();
            rand_step(1'b0);
        end

        // Reset for one clock while slot 2 is on screen
        SPEAKER_OUT = 1'b0;
        for (int i = 0; i < 2 * FRAME && !((k % FRAME) >= 2 * SD + 1 && (k % FRAME) < 3 * SD); i++) tick();
        chk("found_slot2", int'((k % FRAME) >= 2 * SD + 1 && (k % FRAME) < 3 * SD), 1);
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        mins_disp = {7'h11, 7'h22};
        hours_disp = {7'h06, 7'h5B};
        AM_PM_disp = 1'b0;
        chk("midreset_digit", int'(digit_en), 0);
        chk("midreset_seg", int'(seg_out), 0);
        chk("midreset_colon", int'(colon_out), 0);
        repeat (2) tick();
        chk("restart_slot0_digit", int'(digit_en), 4'b0001);
        chk("restart_slot0_seg", int'(seg_out), 7'h22);
        chk("restart_slot0_dp", int'(dp_out), 0);

        // Second randomized run biased toward blank hours tens
        for (int i = 0; i < 600; i++) begin
            tick();
            rand_step(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
